spam_arbiter: RTL and testbench

Round-robin arbiter that shares the single SPAM master port (spamo_*/spami_*) among N requesters, such as the core and a debug/DMA engine. It sits between the requesters and the SPAM device fabric, whose devices' spami outputs are OR-combined. It serializes transactions, holds each grant until the addressed device completes, and returns the read data to the owning requester. A timeout counter guarantees forward progress when no device answers an address.

---
 rtl/spam_arbiter.sv | 152 +++++++++++++++
 tb/tb_spam_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spam_arbiter.sv
// spam_arbiter: round-robin arbiter sharing one SPAM master port among
// N_MASTERS requesters. It serializes transactions, holds each grant until
// the device completes (or a timeout fires) and returns the read data to
// the requester that owns the grant.
module spam_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int TIMEOUT   = 1024,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int DID_W     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS-1:0]        m_valids,
   input  logic [N_MASTERS-1:0]        m_r_nws,
   input  logic [N_MASTERS*DID_W-1:0]  m_dids,
   input  logic [N_MASTERS*ADDR_W-1:0] m_addrs,
   input  logic [N_MASTERS*DATA_W-1:0] m_datas,
   output logic [N_MASTERS-1:0]        m_dones,
   output logic [N_MASTERS-1:0]        m_errs,
   output logic [DATA_W-1:0]           m_rdata,
   output logic                        spamo_valid,
   output logic                        spamo_r_nw,
   output logic [DID_W-1:0]            spamo_did,
   output logic [ADDR_W-1:0]           spamo_addr,
   output logic [DATA_W-1:0]           spamo_data,
   input  logic                        spami_busy_b,
   input  logic [DATA_W-1:0]           spami_data
);

   localparam int GW = $clog2(N_MASTERS);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_reg;
   logic [GW-1:0]         grant_reg;
   logic [GW-1:0]         last_grant_reg;
   logic [CW-1:0]         cnt_reg;
   logic [N_MASTERS-1:0]  m_dones_reg;
   logic [N_MASTERS-1:0]  m_errs_reg;
   logic [DATA_W-1:0]     m_rdata_reg;
   logic                  spamo_valid_reg;
   logic                  spamo_r_nw_reg;
   logic [DID_W-1:0]      spamo_did_reg;
   logic [ADDR_W-1:0]     spamo_addr_reg;
   logic [DATA_W-1:0]     spamo_data_reg;

   // Per-master request fields, unpacked from the flat buses
   logic                  r_nw_arr [N_MASTERS];
   logic [DID_W-1:0]      did_arr  [N_MASTERS];
   logic [ADDR_W-1:0]     addr_arr [N_MASTERS];
   logic [DATA_W-1:0]     data_arr [N_MASTERS];

   for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign r_nw_arr[gi] = m_r_nws[gi];
      assign did_arr[gi]  = m_dids[gi*DID_W +: DID_W];
      assign addr_arr[gi] = m_addrs[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = m_datas[gi*DATA_W +: DATA_W];
   end

   logic          pick_valid;
   logic [GW-1:0] pick_idx;
   int            cand;

   // Round-robin search starting just after the last served master; walking
   // offsets from far to near lets the nearest requester overwrite the pick.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int i = N_MASTERS; i >= 1; i--) begin
         cand = (int'(last_grant_reg) + i) % N_MASTERS;
         if (m_valids[GW'(cand)]) begin
            pick_valid = 1'b1;
            pick_idx   = GW'(cand);
         end
      end
   end

   // Transaction FSM with registered request, completion and data outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         last_grant_reg  <= GW'(N_MASTERS - 1);
         cnt_reg         <= '0;
         m_dones_reg     <= '0;
         m_errs_reg      <= '0;
         m_rdata_reg     <= '0;
         spamo_valid_reg <= 1'b0;
         spamo_r_nw_reg  <= 1'b0;
         spamo_did_reg   <= '0;
         spamo_addr_reg  <= '0;
         spamo_data_reg  <= '0;
      end else begin
         spamo_valid_reg <= 1'b0;
         m_dones_reg     <= '0;
         m_errs_reg      <= '0;
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  grant_reg       <= pick_idx;
                  spamo_r_nw_reg  <= r_nw_arr[pick_idx];
                  spamo_did_reg   <= did_arr[pick_idx];
                  spamo_addr_reg  <= addr_arr[pick_idx];
                  spamo_data_reg  <= data_arr[pick_idx];
                  spamo_valid_reg <= 1'b1;
                  state_reg       <= ISSUE;
               end
            end
            ISSUE: begin
               // Any completion seen during the strobe cycle is stray; ignore it
               cnt_reg   <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (cnt_reg != '1) begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
               // Completion takes priority over a coincident timeout
               if (spami_busy_b) begin
                  m_rdata_reg            <= spami_data;
                  m_dones_reg[grant_reg] <= 1'b1;
                  state_reg              <= DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  m_rdata_reg            <= '1;
                  m_dones_reg[grant_reg] <= 1'b1;
                  m_errs_reg[grant_reg]  <= 1'b1;
                  state_reg              <= DONE;
               end
            end
            DONE: begin
               last_grant_reg <= grant_reg;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign m_dones     = m_dones_reg;
   assign m_errs      = m_errs_reg;
   assign m_rdata     = m_rdata_reg;
   assign spamo_valid = spamo_valid_reg;
   assign spamo_r_nw  = spamo_r_nw_reg;
   assign spamo_did   = spamo_did_reg;
   assign spamo_addr  = spamo_addr_reg;
   assign spamo_data  = spamo_data_reg;

endmodule

// File: tb/tb_spam_arbiter.sv
// Directed testbench for spam_arbiter (two masters, TIMEOUT=8).
module tb_spam_arbiter;

   localparam int NM = 2;
   localparam int TO = 8;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int IW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_valids;
   logic [NM-1:0]    m_r_nws;
   logic [NM*IW-1:0] m_dids;
   logic [NM*AW-1:0] m_addrs;
   logic [NM*DW-1:0] m_datas;
   logic [NM-1:0]    m_dones;
   logic [NM-1:0]    m_errs;
   logic [DW-1:0]    m_rdata;
   logic             spamo_valid;
   logic             spamo_r_nw;
   logic [IW-1:0]    spamo_did;
   logic [AW-1:0]    spamo_addr;
   logic [DW-1:0]    spamo_data;
   logic             spami_busy_b;
   logic [DW-1:0]    spami_data;

   int checks   = 0;
   int failures = 0;

   spam_arbiter #(
      .N_MASTERS(NM), .TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW), .DID_W(IW)
   ) dut (
      .clk(clk), .rst(rst),
      .m_valids(m_valids), .m_r_nws(m_r_nws), .m_dids(m_dids),
      .m_addrs(m_addrs), .m_datas(m_datas),
      .m_dones(m_dones), .m_errs(m_errs), .m_rdata(m_rdata),
      .spamo_valid(spamo_valid), .spamo_r_nw(spamo_r_nw), .spamo_did(spamo_did),
      .spamo_addr(spamo_addr), .spamo_data(spamo_data),
      .spami_busy_b(spami_busy_b), .spami_data(spami_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, spamo_valid, 0);
      check({tag, "_rnw"},   spamo_r_nw, 0);
      check({tag, "_did"},   spamo_did, 0);
      check({tag, "_addr"},  spamo_addr, 0);
      check({tag, "_data"},  spamo_data, 0);
      check({tag, "_dones"}, m_dones, 0);
      check({tag, "_errs"},  m_errs, 0);
      check({tag, "_rdata"}, m_rdata, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      m_valids     = '0;
      m_r_nws      = 2'b11;
      m_dids       = {4'd5, 4'd2};
      m_addrs      = {16'h0020, 16'h0010};
      m_datas      = {32'hBBBB0001, 32'hAAAA0000};
      spami_busy_b = 1'b0;
      spami_data   = '0;

      // Reset state
      repeat (2) tick;
      check_all_zero("reset");
      rst = 1'b0;

      // Single read from master 0, answered 3 cycles after the strobe
      m_valids = 2'b01;
      tick;
      check("rd_strobe", spamo_valid, 1);
      check("rd_addr", spamo_addr, 16'h0010);
      check("rd_did", spamo_did, 2);
      check("rd_rnw", spamo_r_nw, 1);
      tick;
      check("rd_strobe_once", spamo_valid, 0);
      m_addrs[15:0] = 16'h0099;
      tick;
      check("rd_addr_latched", spamo_addr, 16'h0010);
      check("rd_no_early_done", m_dones, 0);
      tick;
      spami_busy_b = 1'b1;
      spami_data   = 32'hDEADBEEF;
      tick;
      check("rd_done", m_dones, 2'b01);
      check("rd_err", m_errs, 0);
      check("rd_rdata", m_rdata, 32'hDEADBEEF);
      spami_busy_b  = 1'b0;
      spami_data    = '0;
      m_valids      = 2'b00;
      m_addrs[15:0] = 16'h0010;
      tick;
      check("rd_done_pulse", m_dones, 0);

      // Async reset during WAIT; master 1 holds the grant at that point
      m_valids = 2'b11;
      tick;
      check("ar_grant1_did", spamo_did, 5);
      tick;
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      tick;
      rst = 1'b0;
      check("ar_no_done", m_dones, 0);
      spami_busy_b = 1'b1;
      spami_data   = 32'hA5A5A5A5;

      // Round robin with both masters requesting, immediate answers
      for (int k = 0; k < 4; k++) begin
         tick;
         check("rr_strobe", spamo_valid, 1);
         check("rr_did", spamo_did, (k % 2 == 0) ? 2 : 5);
         tick;
         check("rr_wait", spamo_valid, 0);
         tick;
         check("rr_done", m_dones, (k % 2 == 0) ? 2'b01 : 2'b10);
         check("rr_rdata", m_rdata, 32'hA5A5A5A5);
         if (k == 3) begin
            spami_busy_b = 1'b0;
            spami_data   = '0;
         end
         tick;
         check("rr_idle", m_dones, 0);
      end

      // Timeout on master 0, then pending master 1 gets served
      tick;
      check("to_strobe", spamo_valid, 1);
      check("to_did", spamo_did, 2);
      for (int i = 1; i <= TO; i++) begin
         tick;
         check("to_pending", m_dones, 0);
      end
      tick;
      check("to_done", m_dones, 2'b01);
      check("to_err", m_errs, 2'b01);
      check("to_rdata", m_rdata, 32'hFFFFFFFF);
      m_valids     = 2'b10;
      spami_busy_b = 1'b1;
      spami_data   = 32'h00001234;
      tick;
      check("to_idle", m_dones, 0);
      tick;
      check("m1_did", spamo_did, 5);
      check("m1_addr", spamo_addr, 16'h0020);
      tick;
      tick;
      check("m1_done", m_dones, 2'b10);
      check("m1_err", m_errs, 0);
      check("m1_rdata", m_rdata, 32'h00001234);
      m_valids     = 2'b01;
      spami_busy_b = 1'b0;
      spami_data   = '0;

      // Completion in the same cycle the counter reaches TIMEOUT-1
      tick;
      tick;
      check("bd_strobe", spamo_valid, 1);
      for (int i = 1; i <= TO - 1; i++) begin
         tick;
         check("bd_pending", m_dones, 0);
      end
      tick;
      spami_busy_b = 1'b1;
      spami_data   = 32'h5;
      m_valids     = 2'b00;
      tick;
      check("bd_done", m_dones, 2'b01);
      check("bd_err", m_errs, 0);
      check("bd_rdata", m_rdata, 32'h5);
      spami_busy_b = 1'b0;
      spami_data   = '0;
      m_valids     = 2'b01;
      m_r_nws      = 2'b10;

      // Stray completion in the ISSUE cycle of a write; must end by timeout
      tick;
      tick;
      check("st_strobe", spamo_valid, 1);
      check("st_rnw", spamo_r_nw, 0);
      check("st_data", spamo_data, 32'hAAAA0000);
      spami_busy_b = 1'b1;
      spami_data   = 32'h77;
      tick;
      spami_busy_b = 1'b0;
      spami_data   = '0;
      check("st_ignored", m_dones, 0);
      for (int i = 2; i <= TO; i++) begin
         tick;
         check("st_pending", m_dones, 0);
      end
      tick;
      check("st_done", m_dones, 2'b01);
      check("st_err", m_errs, 2'b01);
      check("st_rdata", m_rdata, 32'hFFFFFFFF);
      m_valids = 2'b00;
      tick;
      check("st_idle_dones", m_dones, 0);
      check("st_idle_errs", m_errs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
